uart_alu_intf: RTL
==================

Name: uart_alu_intf

Overview:
- Sits between the UART receiver and the UART transmitter, and drives the combinational ALU.
- Collects three received bytes in order: operand A, operand B, then opcode.
- Presents the three values on registered outputs to the ALU, captures the ALU result, and hands it to the transmitter with a start/done handshake.
- Guards against stalled frames with a timeout, and against bytes arriving while busy with an overrun flag.

Parameters:
- N, 8, data width of UART bytes, operands and result.
- OP_W, 6, opcode width; taken from rx_data[OP_W-1:0], with OP_W <= N.
- TIMEOUT_CYCLES, 500000, inter-byte timeout in clk cycles; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  N  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle pulse: rx_data holds a new byte.
- alu_a  out  N  operand A (registered).
- alu_b  out  N  operand B (registered).
- alu_op  out  OP_W  opcode (registered).
- alu_result  in  N  combinational ALU result.
- tx_data  out  N  byte to transmit (registered).
- tx_start  out  1  one-cycle pulse requesting a transmit.
- tx_busy  in  1  transmitter is busy; a start is never issued while this is 1.
- tx_done  in  1  one-cycle pulse: the transmitter has finished a byte.
- frame_err  out  1  one-cycle pulse when a partial frame times out.
- overrun  out  1  sticky flag: a byte arrived while it could not be accepted.

Behaviour:
- Reset is asynchronous. On reset:
  - state = WAIT_A.
  - alu_a, alu_b, alu_op, tx_data = 0.
  - tx_start, frame_err, overrun = 0.
  - timeout counter = 0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX, plus ECHO_SEND and ECHO_WAIT (present only when the optional feature is enabled).
- WAIT_A: on rx_valid, alu_a <= rx_data, go to WAIT_B. No timeout applies in WAIT_A.
- WAIT_B: on rx_valid, alu_b <= rx_data, go to WAIT_OP.
- WAIT_OP: on rx_valid, alu_op <= rx_data[OP_W-1:0], go to EXEC.
- EXEC: lasts exactly one cycle. tx_data <= alu_result, go to SEND. Upper rx bits beyond OP_W are ignored.
- SEND: while tx_busy=1, stay in SEND. When tx_busy=0: tx_start <= 1 for exactly one cycle, go to WAIT_TX.
- WAIT_TX: on tx_done, go to WAIT_A (or ECHO_SEND if the feature is enabled).
  - tx_done is ignored during the cycle in which tx_start=1.
- Latency: if the opcode rx_valid occurs in cycle T and tx_busy=0, tx_start is high in cycle T+3. alu_a, alu_b and alu_op stay stable from T+1 until the next frame's bytes overwrite them.
- Timeout:
  - The counter clears on entry to WAIT_B or WAIT_OP and on every accepted byte. It increments every cycle in WAIT_B and WAIT_OP.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid: go to WAIT_A, and frame_err = 1 for one cycle.
  - Partially loaded alu_a/alu_b keep their values.
  - If rx_valid coincides with expiry, the byte is accepted and frame_err is not raised.
  - The counter is wide enough for TIMEOUT_CYCLES with no wrap-around (it saturates by the transition).
- Overrun: rx_valid in EXEC, SEND, WAIT_TX or the echo states drops the byte and sets overrun = 1. overrun clears only on reset.
- Reset mid-operation: all state is discarded immediately and tx_start drops in the same instant. A transmission already in progress in the transmitter is not affected.

Optional Feature:
- Macro: UART_ALU_ECHO_EN.
- Defined: after the result's tx_done, the block sends a second byte via ECHO_SEND and ECHO_WAIT.
  - The second byte is tx_data <= {zeros, alu_op}.
  - It uses the same tx_busy/tx_start/tx_done rules as the result byte, then returns to WAIT_A.
- Undefined: the echo states and logic are absent, and WAIT_TX goes directly to WAIT_A on tx_done.

Test Plan:
- Normal frame: rx bytes 0x05, 0x03, 0x20 with an ALU model returning A+B, tx_busy=0.
  - alu_a=0x05, alu_b=0x03, alu_op=0x20.
  - tx_data=0x08; tx_start high one cycle at T+3; frame_err=0, overrun=0.
- Back-pressure: tx_busy held at 1 for 50 cycles after the opcode byte.
  - No tx_start while busy.
  - tx_start pulses once, one cycle after tx_busy falls; tx_data is unchanged (0x08).
- Timeout: TIMEOUT_CYCLES=100; send 0x11, then silence.
  - frame_err pulses once, 100 cycles after entering WAIT_B.
  - A following frame 0x02, 0x02, 0x20 yields result 0x04.
- Overrun: pulse rx_valid with 0xAA while in WAIT_TX.
  - Byte dropped; overrun=1 and stays 1; the next frame is processed normally.
- Reset mid-frame: reset asserted after byte B.
  - All outputs return to 0 immediately; the next three bytes form a fresh frame.
- Echo (UART_ALU_ECHO_EN defined): frame 0x05, 0x03, 0x20.
  - Two tx_start pulses: first tx_data=0x08, second tx_data=0x20, each after its own tx_done.

Source files
------------

// File: rtl/uart_alu_intf_if.sv
// Signal bundle between uart_alu_intf and its UART receiver, ALU and UART transmitter.
// slave is the controller side; master is the surrounding datapath side.
interface uart_alu_intf_if #(
   parameter int N    = 8,
   parameter int OP_W = 6
);
   logic [N-1:0]    rx_data;
   logic            rx_valid;
   logic [N-1:0]    alu_a;
   logic [N-1:0]    alu_b;
   logic [OP_W-1:0] alu_op;
   logic [N-1:0]    alu_result;
   logic [N-1:0]    tx_data;
   logic            tx_start;
   logic            tx_busy;
   logic            tx_done;
   logic            frame_err;
   logic            overrun;

   modport slave (
      input  rx_data, rx_valid, alu_result, tx_busy, tx_done,
      output alu_a, alu_b, alu_op, tx_data, tx_start, frame_err, overrun
   );

   modport master (
      output rx_data, rx_valid, alu_result, tx_busy, tx_done,
      input  alu_a, alu_b, alu_op, tx_data, tx_start, frame_err, overrun
   );
endinterface

// File: rtl/uart_alu_intf.sv
// Collects A, B, opcode bytes from the UART, runs them through the ALU and transmits the result.
// Optional opcode echo byte after the result is enabled by defining UART_ALU_ECHO_EN.
//
// state     | meaning
// WAIT_A    | idle, waiting for operand A byte (no timeout)
// WAIT_B    | waiting for operand B byte, timeout running
// WAIT_OP   | waiting for opcode byte, timeout running
// EXEC      | one cycle, capture ALU result into tx_data
// SEND      | waiting for transmitter idle, then pulse tx_start
// WAIT_TX   | waiting for tx_done of the result byte
// ECHO_SEND | (echo build) waiting for idle, send opcode byte
// ECHO_WAIT | (echo build) waiting for tx_done of the echo byte
module uart_alu_intf #(
   parameter int N              = 8,
   parameter int OP_W           = 6,
   parameter int TIMEOUT_CYCLES = 500000
) (
   input logic           clk,
   input logic           reset,
   uart_alu_intf_if.slave bus
);
   localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TC_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] TC = TC_INT[CNT_W-1:0];

   typedef enum logic [2:0] {
      WAIT_A,
      WAIT_B,
      WAIT_OP,
      EXEC,
      SEND,
`ifdef UART_ALU_ECHO_EN
      WAIT_TX,
      ECHO_SEND,
      ECHO_WAIT
`else
      WAIT_TX
`endif
   } state_t;

   state_t          state;
   logic [CNT_W-1:0] tmo_cnt;
   logic [N-1:0]    alu_a;
   logic [N-1:0]    alu_b;
   logic [OP_W-1:0] alu_op;
   logic [N-1:0]    tx_data;
   logic            tx_start;
   logic            frame_err;
   logic            overrun;
   logic            expired;
   logic            busy_state;

   assign expired = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TC);

   // Any state past opcode capture cannot take a new byte.
`ifdef UART_ALU_ECHO_EN
   assign busy_state = (state == EXEC) || (state == SEND) || (state == WAIT_TX) ||
                       (state == ECHO_SEND) || (state == ECHO_WAIT);
`else
   assign busy_state = (state == EXEC) || (state == SEND) || (state == WAIT_TX);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= WAIT_A;
         tmo_cnt   <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         tx_data   <= '0;
         tx_start  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         tx_start  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            WAIT_A: begin
               if (bus.rx_valid) begin
                  alu_a   <= bus.rx_data;
                  tmo_cnt <= '0;
                  state   <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (bus.rx_valid) begin
                  alu_b   <= bus.rx_data;
                  tmo_cnt <= '0;
                  state   <= WAIT_OP;
               end else if (expired) begin
                  frame_err <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= WAIT_A;
               end else if (TIMEOUT_CYCLES != 0) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WAIT_OP: begin
               if (bus.rx_valid) begin
                  alu_op  <= bus.rx_data[OP_W-1:0];
                  tmo_cnt <= '0;
                  state   <= EXEC;
               end else if (expired) begin
                  frame_err <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= WAIT_A;
               end else if (TIMEOUT_CYCLES != 0) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            EXEC: begin
               tx_data <= bus.alu_result;
               state   <= SEND;
            end
            SEND: begin
               if (!bus.tx_busy) begin
                  tx_start <= 1'b1;
                  state    <= WAIT_TX;
               end
            end
            WAIT_TX: begin
               // A done in the start cycle belongs to an earlier transfer.
               if (bus.tx_done && !tx_start) begin
`ifdef UART_ALU_ECHO_EN
                  state <= ECHO_SEND;
`else
                  state <= WAIT_A;
`endif
               end
            end
`ifdef UART_ALU_ECHO_EN
            ECHO_SEND: begin
               if (!bus.tx_busy) begin
                  tx_data  <= N'(alu_op);
                  tx_start <= 1'b1;
                  state    <= ECHO_WAIT;
               end
            end
            ECHO_WAIT: begin
               if (bus.tx_done && !tx_start) state <= WAIT_A;
            end
`endif
            default: state <= WAIT_A;
         endcase
         if (bus.rx_valid && busy_state) overrun <= 1'b1;
      end
   end

   assign bus.alu_a     = alu_a;
   assign bus.alu_b     = alu_b;
   assign bus.alu_op    = alu_op;
   assign bus.tx_data   = tx_data;
   assign bus.tx_start  = tx_start;
   assign bus.frame_err = frame_err;
   assign bus.overrun   = overrun;
endmodule
